// File: rtl/fb_source_arbiter.sv
// fb_source_arbiter: chooses the source for the framebuffer write port.
// It selects either live GBA pixels or a host overlay that is scanned out
// at a fixed pixel pace. The source only changes at a frame boundary, so a
// torn frame never reaches the framebuffer. A stall timeout lets the block
// leave a GBA core that has stopped producing pixels.
//
// Ports:
//   clk, rst        system clock, asynchronous active-high reset
//   freeze          suppress fb_we/fb_vsync and hold all scan/stall state
//   pixel_*         GBA pixel stream (RGB6 data, column, row, strobe)
//   overlay_req     level request for overlay mode
//   overlay_x/y     overlay pixel address being fetched
//   overlay_color   overlay pixel, BGR5 {B[14:10],G[9:5],R[4:0]}
//   overlay_active  overlay is the selected source
//   fb_we/fb_data   framebuffer write strobe and RGB6 pixel
//   fb_vsync        one-cycle frame-start pulse
//   fb_width/height active source geometry; disp_width display width
module fb_source_arbiter #(
  parameter int unsigned SRC_W         = 240,
  parameter int unsigned SRC_H         = 160,
  parameter int unsigned OVL_W         = 256,
  parameter int unsigned OVL_H         = 224,
  parameter int unsigned SRC_DISP_W    = 1080,
  parameter int unsigned OVL_DISP_W    = 960,
  parameter int unsigned PIX_PERIOD    = 15,
  parameter int unsigned FETCH_PHASE   = 12,
  parameter int unsigned STALL_TIMEOUT = 2000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic [17:0] pixel_data,
  input  logic [7:0]  pixel_x,
  input  logic [7:0]  pixel_y,
  input  logic        pixel_we,
  input  logic        overlay_req,
  output logic [7:0]  overlay_x,
  output logic [7:0]  overlay_y,
  input  logic [14:0] overlay_color,
  output logic        overlay_active,
  output logic        fb_we,
  output logic [17:0] fb_data,
  output logic        fb_vsync,
  output logic [8:0]  fb_width,
  output logic [8:0]  fb_height,
  output logic [10:0] disp_width
);

  localparam int unsigned PH_W = (PIX_PERIOD > 1) ? $clog2(PIX_PERIOD) : 1;
  localparam int unsigned ST_W = $clog2(STALL_TIMEOUT + 1);

  typedef enum logic [1:0] {SRC, OVL_SYNC, OVL} state_t;

  state_t          state;
  logic [PH_W-1:0] phase;
  logic [ST_W-1:0] stall;
  logic            frame_end_q;

  logic        src_last_c;
  logic        stall_sat_c;
  logic        ovl_x_last_c;
  logic        ovl_y_last_c;
  logic [17:0] ovl_rgb6_c;

  // Last GBA pixel of a frame, stall saturation and overlay scan boundaries.
  assign src_last_c   = pixel_we && (pixel_x == 8'(SRC_W - 1)) && (pixel_y == 8'(SRC_H - 1));
  assign stall_sat_c  = (stall == ST_W'(STALL_TIMEOUT));
  assign ovl_x_last_c = (overlay_x == 8'(OVL_W - 1));
  assign ovl_y_last_c = (overlay_y == 8'(OVL_H - 1));

  // BGR5 -> RGB6: each channel is shifted left by one bit.
  assign ovl_rgb6_c = {overlay_color[4:0], 1'b0, overlay_color[9:5], 1'b0,
                       overlay_color[14:10], 1'b0};

  // Source-select FSM with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= SRC;
      phase          <= '0;
      stall          <= '0;
      frame_end_q    <= 1'b0;
      overlay_x      <= '0;
      overlay_y      <= '0;
      overlay_active <= 1'b0;
      fb_we          <= 1'b0;
      fb_data        <= '0;
      fb_vsync       <= 1'b0;
      fb_width       <= 9'(SRC_W);
      fb_height      <= 9'(SRC_H);
      disp_width     <= 11'(SRC_DISP_W);
    end else if (freeze) begin
      // Everything holds; a pending frame end is dropped.
      fb_we       <= 1'b0;
      fb_vsync    <= 1'b0;
      frame_end_q <= 1'b0;
    end else begin
      fb_we       <= 1'b0;
      fb_vsync    <= 1'b0;
      frame_end_q <= 1'b0;
      case (state)
        SRC: begin
          fb_we       <= pixel_we;
          fb_data     <= pixel_data;
          frame_end_q <= src_last_c;
          fb_vsync    <= frame_end_q;
          if (pixel_we) begin
            stall <= '0;
          end else if (!stall_sat_c) begin
            stall <= stall + ST_W'(1);
          end
          // The pending vsync above is still emitted when switching away.
          if (overlay_req && (frame_end_q || stall_sat_c)) begin
            state <= OVL_SYNC;
          end
        end

        OVL_SYNC: begin
          overlay_x      <= '0;
          overlay_y      <= '0;
          phase          <= '0;
          overlay_active <= 1'b1;
          fb_width       <= 9'(OVL_W);
          fb_height      <= 9'(OVL_H);
          disp_width     <= 11'(OVL_DISP_W);
          state          <= OVL;
        end

        OVL: begin
          if ((phase == '0) && (overlay_x == '0) && (overlay_y == '0)) begin
            fb_vsync <= 1'b1;
          end
          if (phase == PH_W'(FETCH_PHASE)) begin
            fb_we   <= 1'b1;
            fb_data <= ovl_rgb6_c;
          end
          if (phase == PH_W'(PIX_PERIOD - 1)) begin
            phase <= '0;
            if (ovl_x_last_c) begin
              overlay_x <= '0;
              overlay_y <= ovl_y_last_c ? 8'd0 : overlay_y + 8'd1;
            end else begin
              overlay_x <= overlay_x + 8'd1;
            end
            // Leave only after the final pixel of a complete overlay frame.
            if (ovl_x_last_c && ovl_y_last_c && !overlay_req) begin
              state          <= SRC;
              overlay_active <= 1'b0;
              fb_width       <= 9'(SRC_W);
              fb_height      <= 9'(SRC_H);
              disp_width     <= 11'(SRC_DISP_W);
              stall          <= '0;
            end
          end else begin
            phase <= phase + PH_W'(1);
          end
        end

        default: state <= SRC;
      endcase
    end
  end

endmodule
